led_alert_sequencer: RTL and testbench
======================================

Name: led_alert_sequencer

Overview:
- Sits directly downstream of the red-LED PIO. Consumes its 18-bit out_port word and drives the physical red LEDs.
- Applies a software-selected display effect to the word: steady, blink, chase or PWM dim.
- Software controls it as an Avalon-MM slave on the same system interconnect, so the alarm state can flash without CPU bit-banging.

Parameters:
- WIDTH, 18: LED word width; must equal the PIO out_port width.
- PERIOD_DEFAULT, 2500000: reset value of the PERIOD register; 50 ms step at 50 MHz.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, zero wait states, combinational from registers
- led_word  in  WIDTH  pattern from the red-LED PIO out_port
- led_out  out  WIDTH  registered drive to the LEDR pins

Behaviour:
- Reset: led_out=0, MODE=0, PERIOD=PERIOD_DEFAULT, DUTY=15, prescaler=PERIOD_DEFAULT, phase=1, pos=0, dir=up, pwm_cnt=0. Reset is asynchronous and may occur mid-sequence; every register returns to its reset value immediately.
- Register map. A write is chipselect && !write_n. Readback is zero-extended.
  - 0 CTRL: [1:0] MODE, where 0=steady, 1=blink, 2=chase, 3=dim.
  - 1 PERIOD: [23:0].
  - 2 DUTY: [3:0].
  - 3 STATUS (read-only; writes ignored): [4:0] pos, [5] phase, [6] dir (1=down).
- Prescaler:
  - 24-bit down-counter. Emits a one-cycle step pulse when it is 0, then reloads PERIOD.
  - A step therefore occurs every PERIOD+1 cycles. PERIOD=0 gives a step every cycle.
  - A PERIOD write takes effect at the next reload; the count in progress is not truncated.
- Any CTRL write, even of the same MODE value, restarts the sequence on the following cycle: prescaler=PERIOD, phase=1, pos=0, dir=up.
- Steady: led_out <= led_word.
- Blink:
  - phase toggles on each step.
  - led_out <= phase ? led_word : 0.
  - The first on-interval after a restart is PERIOD+1 cycles.
- Chase:
  - On each step, pos moves by one in direction dir.
  - At pos=WIDTH-1 with dir=up, dir flips and the next step goes to WIDTH-2. The mirror rule applies at pos=0 with dir=down. No position dwells twice.
  - led_out <= led_word & (1<<pos). LEDs whose bit in led_word is 0 stay dark.
- Dim:
  - pwm_cnt is a 4-bit free-running counter that advances every cycle and wraps 15->0.
  - led_out <= (DUTY==15 || pwm_cnt<DUTY) ? led_word : 0.
  - DUTY=0 gives fully dark.
- Latency: led_out reflects led_word and state one clock later. A led_word change mid-blink or mid-chase does not restart the sequence.
- A simultaneous CTRL write and step pulse: the restart wins.
- Unused writedata bits are ignored. Reads have no side effects.

Decomposition:
- Shared package holds:
  - register address constants: ADDR_CTRL, ADDR_PERIOD, ADDR_DUTY, ADDR_STATUS
  - mode encodings: MODE_STEADY, MODE_BLINK, MODE_CHASE, MODE_DIM
  - PERIOD field width (24)
- One natural sub-module, led_step_prescaler. It holds the reloadable down-counter and has ports clk, reset_n, restart, period, step.
- Register file, effect state and output mux stay in the top module.

Test Plan:
- Reset with led_word=18'h3FFFF, no writes -> led_out=18'h3FFFF from the second clock on (steady); reading addr 1 returns 2500000.
- Write PERIOD=3, then CTRL=1, led_word=18'h00F0F -> led_out alternates 18'h00F0F for 4 cycles and 0 for 4 cycles, starting the cycle after the CTRL write plus one.
- PERIOD=0, CTRL=2, led_word=18'h3FFFF -> led_out one-hot walks bit0..bit17, then bit16..bit0, with no repeat at the ends; STATUS dir bit flips at pos 17 and at pos 0.
- CTRL=3 with DUTY=4, 0 and 15, led_word=18'h3FFFF -> over a 16-cycle window, led_out is nonzero on 4, 0 and 16 cycles respectively.
- In chase at pos=9, rewrite CTRL=2 on the same cycle as a step pulse -> the next STATUS shows pos=0, dir=up.
- Assert reset_n low mid-blink with phase=0, asynchronously between clock edges -> led_out=0 and all registers return to reset values immediately; after release, steady mode resumes.

Source files
------------

// File: rtl/led_alert_sequencer_pkg.sv
// rtl/led_alert_sequencer_pkg.sv - shared register map, mode encodings and field widths
package led_alert_sequencer_pkg;

  localparam int PERIOD_W = 24;
  localparam int POS_W    = 5;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    MODE_STEADY = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_DIM    = 2'd3
  } mode_e;

endpackage

// File: rtl/led_step_prescaler.sv
// rtl/led_step_prescaler.sv - reloadable down-counter emitting one step every period+1 cycles
module led_step_prescaler
  import led_alert_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD_DEFAULT = 2500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  assign step = (cnt_q == '0);

  // a new period only lands on reload, so an in-flight count is never truncated
  always_comb begin
    cnt_d = cnt_q - PERIOD_W'(1);
    if (restart || step) cnt_d = period;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= PERIOD_W'(PERIOD_DEFAULT);
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_alert_sequencer.sv
// rtl/led_alert_sequencer.sv - Avalon-controlled steady/blink/chase/dim effect on the red-LED word
module led_alert_sequencer
  import led_alert_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH          = 18,
  parameter int unsigned PERIOD_DEFAULT = 2500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] led_word,
  output logic [WIDTH-1:0] led_out
);

  mode_e               mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          duty_q, duty_d;
  logic                phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [WIDTH-1:0]    led_q, led_d;

  logic wr_en, ctrl_wr, step;

  assign wr_en   = chipselect && !write_n;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);

  led_step_prescaler #(
    .PERIOD_DEFAULT(PERIOD_DEFAULT)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(ctrl_wr),
    .period (period_q),
    .step   (step)
  );

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    pwm_d    = pwm_q + 4'd1;
    led_d    = led_word;

    if (wr_en) begin
      case (address)
        ADDR_CTRL:   mode_d   = mode_e'(writedata[1:0]);
        ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
        ADDR_DUTY:   duty_d   = writedata[3:0];
        default:     ;
      endcase
    end

    // a CTRL write swallows any coincident step
    if (ctrl_wr) begin
      phase_d = 1'b1;
      pos_d   = '0;
      dir_d   = 1'b0;
    end else if (step) begin
      if (mode_q == MODE_BLINK) phase_d = ~phase_q;
      if (mode_q == MODE_CHASE) begin
        if (!dir_q) begin
          if (pos_q == POS_W'(WIDTH - 1)) begin
            dir_d = 1'b1;
            pos_d = POS_W'(WIDTH - 2);
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else begin
          if (pos_q == '0) begin
            dir_d = 1'b0;
            pos_d = POS_W'(1);
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
    end

    case (mode_q)
      MODE_STEADY: led_d = led_word;
      MODE_BLINK:  led_d = phase_q ? led_word : '0;
      MODE_CHASE:  led_d = led_word & (WIDTH'(1) << pos_q);
      MODE_DIM:    led_d = (duty_q == 4'd15 || pwm_q < duty_q) ? led_word : '0;
      default:     led_d = led_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_STEADY;
      period_q <= PERIOD_W'(PERIOD_DEFAULT);
      duty_q   <= 4'd15;
      phase_q  <= 1'b1;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      pwm_q    <= '0;
      led_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
    end
  end

  assign led_out = led_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, mode_q};
      ADDR_PERIOD: readdata = {{(32 - PERIOD_W){1'b0}}, period_q};
      ADDR_DUTY:   readdata = {28'd0, duty_q};
      ADDR_STATUS: readdata = {25'd0, dir_q, phase_q, pos_q};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_alert_sequencer.sv
// tb/tb_led_alert_sequencer.sv - scoreboard bench for led_alert_sequencer
module tb_led_alert_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] led_word;
  logic [17:0] led_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [17:0] led;
    logic [6:0]  st;
    logic        st_en;
  } exp_t;

  exp_t sb[$];

  led_alert_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_word  (led_word),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    r = readdata;
    chipselect = 1'b0;
  endtask

  task automatic drain(input int n);
    exp_t        e;
    logic [31:0] r;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("led", {14'd0, led_out}, {14'd0, e.led});
        if (e.st_en) begin
          rd(2'd3, r);
          chk("status", r, {25'd0, e.st});
        end
      end
    end
  endtask

  task automatic count_on(input string tag, input int exp_n);
    int n = 0;
    repeat (16) begin
      @(posedge clk);
      @(negedge clk);
      if (led_out != 18'd0) n++;
    end
    chk(tag, n, exp_n);
  endtask

  function automatic int chase_pos(input int k);
    if (k <= 17)      return k;
    else if (k <= 34) return 34 - k;
    else              return 1;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    exp_t        e;

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    led_word   = 18'h3FFFF;
    #12;
    chk("rst_led", {14'd0, led_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("steady_led", {14'd0, led_out}, 32'h3FFFF);
    rd(2'd1, r); chk("rst_period", r, 32'd2500000);
    rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
    rd(2'd2, r); chk("rst_duty", r, 32'd15);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, r); chk("status_ro", r, 32'h20);

    // blink: 4 on, 4 off, 4 on
    led_word = 18'h00F0F;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 12; i++) begin
      e.led   = (i / 4 == 1) ? 18'd0 : 18'h00F0F;
      e.st    = '0;
      e.st_en = 1'b0;
      sb.push_back(e);
    end
    drain(12);
    rd(2'd3, r); chk("blink_phase0", r, 32'h00);

    // asynchronous reset mid-blink
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_led", {14'd0, led_out}, 32'd0);
    rd(2'd0, r); chk("arst_ctrl", r, 32'd0);
    rd(2'd1, r); chk("arst_period", r, 32'd2500000);
    rd(2'd2, r); chk("arst_duty", r, 32'd15);
    rd(2'd3, r); chk("arst_status", r, 32'h20);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arst_steady", {14'd0, led_out}, 32'h00F0F);

    // chase bounce with STATUS tracking
    led_word = 18'h3FFFF;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd2);
    for (int k = 1; k <= 35; k++) begin
      e.led   = 18'd1 << chase_pos(k - 1);
      e.st    = {(k >= 18 && k <= 34) ? 1'b1 : 1'b0, 1'b1, 5'(chase_pos(k))};
      e.st_en = 1'b1;
      sb.push_back(e);
    end
    drain(35);

    // restart colliding with a step at pos 9
    @(negedge clk);
    wr(2'd0, 32'd2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rd(2'd3, r); chk("pos9", r, 32'h29);
    wr(2'd0, 32'd2);
    rd(2'd3, r); chk("restart_wins", r, 32'h20);
    chk("restart_led", {14'd0, led_out}, 32'h00200);
    @(posedge clk);
    @(negedge clk);
    rd(2'd3, r); chk("after_restart", r, 32'h21);

    // dim
    wr(2'd2, 32'd4);
    wr(2'd0, 32'd3);
    count_on("dim4", 4);
    wr(2'd2, 32'd0);
    count_on("dim0", 0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, r); chk("duty_rd", r, 32'd15);
    count_on("dim15", 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
